instr_fetch_sequencer: RTL and testbench

- Sequences a byte-wide, synchronous-read instruction memory and assembles 24-bit big-endian instructions. Byte at PC goes to [23:16], PC+1 to [15:8], PC+2 to [7:0].
- Owns the fetch PC. Presents each instruction to the core with a valid/ready handshake.
- Supports PC redirect (branch/jump) and flags out-of-range fetches.
- Sits between the core control path and the instruction memory array.

---
 rtl/instr_fetch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Byte-serial instruction fetch: reads three bytes from a synchronous-read memory, presents a 24-bit instruction.
// Optional FETCH_PERFCNT_EN adds saturating FetchCount / StallCount outputs.
module instr_fetch_sequencer #(
  parameter int                ADDR_W    = 24,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [7:0]        MemRdData,
  output logic [23:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              FetchFault
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [15:0]       FetchCount,
  output logic [15:0]       StallCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAP0,
    S_CAP1,
    S_CAP2,
    S_VALID,
    S_FAULT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_inc2;
  logic [ADDR_W-1:0] pc_inc3;
  logic [ADDR_W:0]   pc_end;
  logic              out_of_range;
  logic              accept;

  assign pc_inc1 = pc + ADDR_W'(1);
  assign pc_inc2 = pc + ADDR_W'(2);
  assign pc_inc3 = pc + ADDR_W'(3);

  // One extra bit so a PC near the top of the address space faults rather than wrapping into range.
  assign pc_end       = {1'b0, pc} + (ADDR_W+1)'(2);
  assign out_of_range = (pc_end >= (ADDR_W+1)'(MEM_DEPTH));
  assign accept       = (state == S_VALID) && InstrReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory strobes are decoded from the current state; data lands in the following state.
  always_comb begin
    state_nxt = state;
    MemRdEn   = 1'b0;
    MemAddr   = '0;
    case (state)
      S_IDLE: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (out_of_range) begin
          state_nxt = S_FAULT;
        end else begin
          MemRdEn   = 1'b1;
          MemAddr   = pc;
          state_nxt = S_CAP0;
        end
      end
      S_CAP0: begin
        MemRdEn   = 1'b1;
        MemAddr   = pc_inc1;
        state_nxt = S_CAP1;
      end
      S_CAP1: begin
        MemRdEn   = 1'b1;
        MemAddr   = pc_inc2;
        state_nxt = S_CAP2;
      end
      S_CAP2: begin
        state_nxt = S_VALID;
      end
      S_VALID: begin
        if (InstrReady) begin
          state_nxt = S_ISSUE;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (Redirect) begin
      state_nxt = S_ISSUE;
    end
  end

  // Redirect overrides everything; bytes already captured are simply left behind and overwritten.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      Instruction <= '0;
      InstrPC     <= '0;
      InstrValid  <= 1'b0;
      FetchFault  <= 1'b0;
    end else if (Redirect) begin
      pc         <= RedirectPC;
      InstrValid <= 1'b0;
      FetchFault <= 1'b0;
    end else begin
      case (state)
        S_ISSUE: begin
          if (out_of_range) begin
            FetchFault  <= 1'b1;
            Instruction <= '0;
          end
        end
        S_CAP0: Instruction[23:16] <= MemRdData;
        S_CAP1: Instruction[15:8]  <= MemRdData;
        S_CAP2: begin
          Instruction[7:0] <= MemRdData;
          InstrPC          <= pc;
          InstrValid       <= 1'b1;
        end
        S_VALID: begin
          if (InstrReady) begin
            pc         <= pc_inc3;
            InstrValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERFCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters ignore Redirect: a redirected handshake still counts as an accepted fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (accept) begin
        FetchCount <= sat_inc(FetchCount);
      end
      if ((state == S_VALID) && !InstrReady) begin
        StallCount <= sat_inc(StallCount);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus randomized traffic against a fetch-level model.
module tb_instr_fetch_sequencer;
  localparam int          ADDR_W = 24;
  localparam int          DEPTH  = 128;
  localparam logic [23:0] RPC    = 24'h0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Redirect = 1'b0;
  logic [23:0] RedirectPC = '0;
  logic [23:0] MemAddr;
  logic        MemRdEn;
  logic [7:0]  MemRdData = 8'h00;
  logic [23:0] Instruction;
  logic [23:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        FetchFault;
`ifdef FETCH_PERFCNT_EN
  logic [15:0] FetchCount;
  logic [15:0] StallCount;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [7:0] mem [0:DEPTH-1];

  always #5 Clock = ~Clock;

  instr_fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .MemAddr    (MemAddr),
    .MemRdEn    (MemRdEn),
    .MemRdData  (MemRdData),
    .Instruction(Instruction),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .FetchFault (FetchFault)
`ifdef FETCH_PERFCNT_EN
    ,
    .FetchCount (FetchCount),
    .StallCount (StallCount)
`endif
  );

  // Synchronous-read byte memory
  always @(posedge Clock) begin
    if (MemRdEn && (int'(MemAddr) < DEPTH)) MemRdData <= mem[int'(MemAddr)];
  end

  function automatic logic [23:0] word_at(input logic [23:0] a);
    return {mem[int'(a)], mem[int'(a) + 1], mem[int'(a) + 2]};
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Fetch-level model: m_k counts cycles into the current fetch (-1 = dead cycle after reset).
  logic [23:0] m_pc;
  logic [23:0] m_ipc;
  int          m_k;
  bit          m_valid;
  bit          m_fault;
  logic [15:0] m_fc;
  logic [15:0] m_sc;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_pc <= RPC; m_ipc <= '0; m_k <= -1; m_valid <= 1'b0; m_fault <= 1'b0;
      m_fc <= '0; m_sc <= '0;
    end else begin
      if (m_valid && InstrReady)  m_fc <= sat16(m_fc);
      if (m_valid && !InstrReady) m_sc <= sat16(m_sc);
      if (Redirect) begin
        m_pc <= RedirectPC; m_k <= 0; m_valid <= 1'b0; m_fault <= 1'b0;
      end else if (m_fault) begin
        m_k <= m_k;
      end else if (m_k < 0) begin
        m_k <= 0;
      end else if (m_k == 0) begin
        if (int'(m_pc) + 2 >= DEPTH) m_fault <= 1'b1;
        else m_k <= 1;
      end else if (m_k < 3) begin
        m_k <= m_k + 1;
      end else if (m_k == 3) begin
        m_valid <= 1'b1; m_ipc <= m_pc; m_k <= 4;
      end else if (InstrReady) begin
        m_pc <= m_pc + 24'd3; m_valid <= 1'b0; m_k <= 0;
      end
    end
  end

  bit          e_rden;
  logic [23:0] e_addr;

  always @(negedge Clock) begin
    if (chk_en) begin
      e_rden = !m_fault && ((m_k == 0 && int'(m_pc) + 2 < DEPTH) || m_k == 1 || m_k == 2);
      e_addr = e_rden ? m_pc + 24'(m_k) : 24'h0;
      check("cyc_rden",  32'(MemRdEn),    32'(e_rden));
      check("cyc_addr",  32'(MemAddr),    32'(e_addr));
      check("cyc_valid", 32'(InstrValid), 32'(m_valid));
      check("cyc_fault", 32'(FetchFault), 32'(m_fault));
      if (m_valid) begin
        check("cyc_instr", 32'(Instruction), 32'(word_at(m_ipc)));
        check("cyc_ipc",   32'(InstrPC),     32'(m_ipc));
      end
      if (m_fault) check("cyc_fault_instr", 32'(Instruction), 32'h0);
`ifdef FETCH_PERFCNT_EN
      check("cyc_fetchcnt", 32'(FetchCount), 32'(m_fc));
      check("cyc_stallcnt", 32'(StallCount), 32'(m_sc));
`endif
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!InstrValid && n < 40) begin
      tick();
      n++;
    end
    check(nm, 32'(InstrValid), 32'h1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rden"},  32'(MemRdEn),     32'h0);
    check({nm, "_addr"},  32'(MemAddr),     32'h0);
    check({nm, "_instr"}, 32'(Instruction), 32'h0);
    check({nm, "_ipc"},   32'(InstrPC),     32'h0);
    check({nm, "_valid"}, 32'(InstrValid),  32'h0);
    check({nm, "_fault"}, 32'(FetchFault),  32'h0);
  endtask

  task automatic count_first_valid(input string nm);
    int n;
    n = 0;
    while (!InstrValid && n < 20) begin
      tick();
      n++;
    end
    check(nm, 32'(n), 32'd5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;

    Reset = 1'b0;
    #1 Reset = 1'b1;
    chk_en = 1'b1;
    InstrReady = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");

    // First fetch: IDLE cycle, then ISSUE..CAP2, valid seen after the 5th edge from release
    Reset = 1'b0;
    count_first_valid("first_valid_edges");
    check("first_instr", 32'(Instruction), 32'h123456);
    check("first_ipc",   32'(InstrPC),     32'h0);
    tick();
    check("next_issue_rden", 32'(MemRdEn), 32'h1);
    check("next_issue_addr", 32'(MemAddr), 32'h3);

    // Stall ten cycles in VALID
    InstrReady = 1'b0;
    wait_valid("stall_valid_seen");
    for (int i = 0; i < 10; i++) begin
      check("stall_ipc",  32'(InstrPC),    32'h3);
      check("stall_rden", 32'(MemRdEn),    32'h0);
      check("stall_vld",  32'(InstrValid), 32'h1);
      tick();
    end
    InstrReady = 1'b1;
    tick();
    check("after_stall_addr", 32'(MemAddr), 32'h6);
`ifdef FETCH_PERFCNT_EN
    check("stall_count", 32'(StallCount), 32'd10);
    check("fetch_count", 32'(FetchCount), 32'd2);
`endif

    // Redirect to 0x40 during CAP1
    InstrReady = 1'b0;
    tick();
    tick();
    check("cap1_addr", 32'(MemAddr), 32'h8);
    Redirect = 1'b1; RedirectPC = 24'h40;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("redir_rden", 32'(MemRdEn), 32'h1);
      check("redir_addr", 32'(MemAddr), 32'(24'h40 + 24'(i)));
      tick();
    end
    wait_valid("redir_valid_seen");
    check("redir_ipc",   32'(InstrPC),     32'h40);
    check("redir_instr", 32'(Instruction), 32'(word_at(24'h40)));

    // Redirect coincident with handshake at PC=0
    Redirect = 1'b1; RedirectPC = 24'h0;
    tick();
    Redirect = 1'b0;
    wait_valid("pc0_valid_seen");
    check("pc0_ipc",   32'(InstrPC),     32'h0);
    check("pc0_instr", 32'(Instruction), 32'h123456);
    Redirect = 1'b1; RedirectPC = 24'h10; InstrReady = 1'b1;
    tick();
    Redirect = 1'b0; InstrReady = 1'b0;
    check("coinc_vld_drop", 32'(InstrValid), 32'h0);
    wait_valid("coinc_valid_seen");
    check("coinc_ipc", 32'(InstrPC), 32'h10);
`ifdef FETCH_PERFCNT_EN
    check("coinc_fetch_count", 32'(FetchCount), 32'd3);
`endif

    // Redirect to 126 faults without reading
    Redirect = 1'b1; RedirectPC = 24'd126;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("fault_rden", 32'(MemRdEn),    32'h0);
      check("fault_vld",  32'(InstrValid), 32'h0);
      tick();
    end
    check("fault_flag",  32'(FetchFault),  32'h1);
    check("fault_instr", 32'(Instruction), 32'h0);
    Redirect = 1'b1; RedirectPC = 24'h0;
    tick();
    Redirect = 1'b0;
    check("fault_clear", 32'(FetchFault), 32'h0);
    wait_valid("resume_valid_seen");
    check("resume_ipc", 32'(InstrPC), 32'h0);

    // Last in-range fetch at 125, then PC=128 faults; top-of-space PC faults instead of wrapping
    InstrReady = 1'b1;
    Redirect = 1'b1; RedirectPC = 24'd125;
    tick();
    Redirect = 1'b0;
    wait_valid("edge_valid_seen");
    check("edge_ipc", 32'(InstrPC), 32'd125);
    tick();
    tick();
    check("edge_fault", 32'(FetchFault), 32'h1);
    Redirect = 1'b1; RedirectPC = 24'hFFFFFF;
    tick();
    Redirect = 1'b0;
    check("top_clear", 32'(FetchFault), 32'h0);
    check("top_rden",  32'(MemRdEn),    32'h0);
    tick();
    check("top_fault", 32'(FetchFault), 32'h1);

    // Reset asserted during CAP0
    Redirect = 1'b1; RedirectPC = 24'h0;
    tick();
    Redirect = 1'b0;
    wait_valid("prereset_valid_seen");
    tick();
    tick();
    check("cap0_addr", 32'(MemAddr), 32'h4);
    Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    Reset = 1'b0;
    count_first_valid("rerun_valid_edges");
    check("rerun_ipc", 32'(InstrPC), 32'(RPC));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      Redirect = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       RedirectPC = 24'hFFFFFF - 24'($urandom_range(0, 3));
        1:       RedirectPC = 24'($urandom_range(120, 130));
        default: RedirectPC = 24'($urandom_range(0, 125));
      endcase
      InstrReady = 1'($urandom_range(0, 1));
      tick();
    end
    Redirect = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
